// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} div_state_t;

  // Bit patterns for the extreme values of a w-bit two's-complement number (w <= 64).
  function automatic logic [63:0] max_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned dividend_width);
    return $clog2(dividend_width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] prem_i,
  input  logic             bit_i,
  input  logic [Width-1:0] dabs_i,
  output logic [Width-1:0] prem_o,
  output logic             qbit_o
);

  logic [Width:0] shifted;

  always_comb begin
    shifted = {prem_i, bit_i};
    qbit_o  = shifted >= {1'b0, dabs_i};
    prem_o  = qbit_o ? Width'(shifted - {1'b0, dabs_i}) : shifted[Width-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_AREA_LOG_EN to add simulation-only area accounting into tbench_top.area.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH  = 32,
  parameter int unsigned DIVISOR_WIDTH   = 16,
  parameter int unsigned QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int unsigned REMAINDER_WIDTH = DIVISOR_WIDTH
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic [DIVIDEND_WIDTH-1:0]  dividend,
  input  logic [DIVISOR_WIDTH-1:0]   divisor,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [QUOTIENT_WIDTH-1:0]  quotient,
  output logic [REMAINDER_WIDTH-1:0] remainder,
  output logic                       div_by_zero,
  output logic                       overflow,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned CNT_WIDTH = cnt_width(DIVIDEND_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LastIter = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

  div_state_t                 state_q;
  // Holds |dividend| and shifts quotient bits in at the LSB; ends up as |quotient|.
  logic [DIVIDEND_WIDTH-1:0]  a_q;
  logic [DIVISOR_WIDTH-1:0]   prem_q;
  logic [DIVISOR_WIDTH-1:0]   dabs_q;
  logic                       q_neg_q;
  logic                       r_neg_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic [QUOTIENT_WIDTH-1:0]  quot_q;
  logic [REMAINDER_WIDTH-1:0] rem_q;
  logic                       dbz_q;
  logic                       ovf_q;

  // Magnitudes are unsigned; -(most negative) wraps to 2^(N-1), which is exact as unsigned.
  logic [DIVIDEND_WIDTH-1:0]  dvd_abs;
  logic [DIVISOR_WIDTH-1:0]   dvs_abs;
  logic [DIVIDEND_WIDTH-1:0]  q_res;
  logic [DIVISOR_WIDTH-1:0]   r_res;
  logic                       is_ovf;
  logic [DIVISOR_WIDTH-1:0]   prem_d;
  logic                       qbit;

  always_comb begin
    dvd_abs = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
    dvs_abs = divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
    is_ovf  = (dividend == DIVIDEND_WIDTH'(min_neg(DIVIDEND_WIDTH))) && (divisor == '1);
    q_res   = q_neg_q ? -a_q : a_q;
    r_res   = r_neg_q ? -prem_q : prem_q;
  end

  div_step #(
    .Width (DIVISOR_WIDTH)
  ) u_div_step (
    .prem_i (prem_q),
    .bit_i  (a_q[DIVIDEND_WIDTH-1]),
    .dabs_i (dabs_q),
    .prem_o (prem_d),
    .qbit_o (qbit)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= IDLE;
      a_q         <= '0;
      prem_q      <= '0;
      dabs_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            prem_q     <= '0;
            a_q        <= dvd_abs;
            dabs_q     <= dvs_abs;
            q_neg_q    <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
            r_neg_q    <= dividend[DIVIDEND_WIDTH-1];
            if (divisor == '0) begin
              quot_q      <= dividend[DIVIDEND_WIDTH-1] ?
                             QUOTIENT_WIDTH'(min_neg(QUOTIENT_WIDTH)) :
                             QUOTIENT_WIDTH'(max_pos(QUOTIENT_WIDTH));
              rem_q       <= REMAINDER_WIDTH'($signed(dividend));
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (is_ovf) begin
              quot_q      <= QUOTIENT_WIDTH'(max_pos(QUOTIENT_WIDTH));
              rem_q       <= '0;
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          a_q    <= {a_q[DIVIDEND_WIDTH-2:0], qbit};
          prem_q <= prem_d;
          if (cnt_q == LastIter) begin
            cnt_q   <= '0;
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        FIXUP: begin
          quot_q      <= QUOTIENT_WIDTH'($signed(q_res));
          rem_q       <= REMAINDER_WIDTH'($signed(r_res));
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

`ifdef SEQ_DIVIDER_AREA_LOG_EN
  initial begin
    #0;
    tbench_top.area = tbench_top.area + 300 * DIVIDEND_WIDTH;
    $display("%m: area += %0d", 300 * DIVIDEND_WIDTH);
  end
`else
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized traffic vs. a model.
module tb_seq_divider;

  localparam int unsigned DvdW = 32;
  localparam int unsigned DvsW = 16;

  logic            clk = 1'b0;
  logic            arst_n_in = 1'b0;
  logic [DvdW-1:0] dividend = '0;
  logic [DvsW-1:0] divisor = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DvdW-1:0] quotient;
  logic [DvsW-1:0] remainder;
  logic            div_by_zero;
  logic            overflow;
  logic            out_valid;
  logic            out_ready = 1'b0;

  seq_divider #(
    .DIVIDEND_WIDTH  (DvdW),
    .DIVISOR_WIDTH   (DvsW),
    .QUOTIENT_WIDTH  (DvdW),
    .REMAINDER_WIDTH (DvsW)
  ) dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .dividend    (dividend),
    .divisor     (divisor),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [DvdW-1:0] q;
    logic [DvsW-1:0] r;
    logic            dbz;
    logic            ovf;
    int              lat;  // edges after the accept edge until out_valid is visible
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain signed arithmetic with truncating division.
  function automatic exp_t model(input logic [DvdW-1:0] a, input logic [DvsW-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = DvdW + 1;
    if (sb == 0) begin
      e.q   = (sa >= 0) ? 32'h7fff_ffff : 32'h8000_0000;
      e.r   = a[DvsW-1:0];
      e.dbz = 1'b1;
      e.lat = 0;
    end else if (a == 32'h8000_0000 && b == 16'hffff) begin
      e.q   = 32'h7fff_ffff;
      e.r   = '0;
      e.ovf = 1'b1;
      e.lat = 0;
    end else begin
      e.q = 32'(sa / sb);
      e.r = 16'(sa % sb);
    end
    return e;
  endfunction

  // Model state: one operation in flight at most.
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   inflight = 1'b0;
  exp_t cur;

  always @(posedge clk or negedge arst_n_in) begin
    bit was;
    bit due;
    if (!arst_n_in) begin
      inflight = 1'b0;
    end else begin
      was = inflight;
      due = inflight && (cyc - acc_cyc >= cur.lat);
      cyc++;
      if (due && out_ready) inflight = 1'b0;
      if (!was && in_valid) begin
        cur      = model(dividend, divisor);
        inflight = 1'b1;
        acc_cyc  = cyc;
      end
    end
  end

  always @(negedge clk) begin
    bit due;
    if (!arst_n_in) begin
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset flags", {div_by_zero, overflow}, 0);
    end else begin
      due = inflight && (cyc - acc_cyc >= cur.lat);
      check("in_ready", in_ready, !inflight);
      check("out_valid", out_valid, due);
      if (due && out_valid) begin
        check("quotient", quotient, cur.q);
        check("remainder", remainder, cur.r);
        check("div_by_zero", div_by_zero, cur.dbz);
        check("overflow", overflow, cur.ovf);
      end
    end
  end

  // Issue one op, measure latency in cycles (accept = cycle 0), hold out_ready low for 'hold'.
  task automatic expect_op(input string name, input logic [DvdW-1:0] a,
                           input logic [DvsW-1:0] b, input int hold,
                           input logic [DvdW-1:0] eq, input logic [DvsW-1:0] er,
                           input logic edbz, input logic eovf, input int elat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " in_ready before accept"}, in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, elat);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_by_zero"}, div_by_zero, edbz);
    check({name, " overflow"}, overflow, eovf);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check({name, " in_ready while held"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " in_ready after handshake"}, in_ready, 1);
    check({name, " out_valid after handshake"}, out_valid, 0);
  endtask

  initial begin
    exp_t e;
    int   sent;
    int   guard;
    int   kind;
    bit   rdy;

    e = model(32'd100, 16'd7);
    check("model 100/7 q", e.q, 32'd14);
    check("model 100/7 r", e.r, 16'd2);
    e = model(-32'sd100, 16'd7);
    check("model -100/7 q", e.q, 32'hffff_fff2);
    check("model -100/7 r", e.r, 16'hfffe);

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;

    expect_op("100/7", 32'd100, 16'd7, 0, 32'd14, 16'd2, 0, 0, 34);
    expect_op("-100/7", -32'sd100, 16'd7, 0, -32'sd14, -16'sd2, 0, 0, 34);
    expect_op("100/-7", 32'd100, -16'sd7, 0, -32'sd14, 16'd2, 0, 0, 34);
    expect_op("-100/-7", -32'sd100, -16'sd7, 0, 32'd14, -16'sd2, 0, 0, 34);
    expect_op("min/-1", 32'h8000_0000, 16'hffff, 0, 32'h7fff_ffff, 16'd0, 0, 1, 1);
    expect_op("5/0", 32'd5, 16'd0, 0, 32'h7fff_ffff, 16'd5, 1, 0, 1);
    expect_op("-5/0", -32'sd5, 16'd0, 0, 32'h8000_0000, 16'hfffb, 1, 0, 1);
    expect_op("0/123", 32'd0, 16'd123, 0, 32'd0, 16'd0, 0, 0, 34);
    expect_op("min/1", 32'h8000_0000, 16'd1, 0, 32'h8000_0000, 16'd0, 0, 0, 34);
    expect_op("backpressure 1234/5", 32'd1234, 16'd5, 10, 32'd246, 16'd4, 0, 0, 34);
    expect_op("back-to-back 77/-8", 32'd77, -16'sd8, 0, -32'sd9, 16'd5, 0, 0, 34);

    // Reset in the middle of an operation.
    dividend = 32'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    arst_n_in = 1'b0;
    #1;
    check("mid-busy reset in_ready", in_ready, 1);
    check("mid-busy reset out_valid", out_valid, 0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    check("after reset no out_valid", out_valid, 0);
    expect_op("9/2 after reset", 32'd9, 16'd2, 0, 32'd4, 16'd1, 0, 0, 34);

    // Random traffic; in_valid is held while the divider is busy.
    sent  = 0;
    guard = 0;
    while ((sent < 150 || in_valid || inflight) && guard < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 150 && $urandom_range(0, 1) == 1) begin
        kind = $urandom_range(0, 9);
        dividend = $urandom;
        divisor  = 16'($urandom);
        if (kind == 0) divisor = '0;
        if (kind == 1) begin
          dividend = 32'h8000_0000;
          divisor  = 16'hffff;
        end
        if (kind == 2) dividend = '0;
        if (kind == 3) begin
          dividend = 32'($signed(16'($urandom)));
          divisor  = 16'($signed(4'($urandom)));
        end
        if (kind == 4) divisor = 16'h8000;
        in_valid = 1'b1;
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        in_valid = 1'b0;
        sent++;
      end
      guard++;
    end
    check("random traffic drained", guard < 20000, 1);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
